// File: rtl/calculator_pkg.sv
// Shared widths and the packer FSM encoding for the adder -> memory write path.
package calculator_pkg;
  localparam int DATA_W        = 32;
  localparam int MEM_WORD_SIZE = 64;

  typedef enum logic {P_LOW, P_HIGH} pack_state_t;
endpackage

// File: rtl/word_fifo.sv
// Small first-word-fall-through FIFO; head is zero when empty, flush beats push/pop.
module word_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic [CW-1:0]    count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [AW-1:0]               wr_q, rd_q;
  logic [CW-1:0]               count_q, count_d;
  logic                        do_push, do_pop;

  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign data_o  = valid_o ? mem_q[rd_q] : '0;

  assign do_pop  = pop_i & valid_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: data_o is masked by valid_o.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/result_packer.sv
// Pairs lower/upper adder halves into one memory word, queues words, tracks carry and errors.
module result_packer #(
  parameter int DATA_W        = 32,
  parameter int MEM_WORD_SIZE = 64,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             res_valid_i,
  input  logic                             res_half_i,
  input  logic [DATA_W-1:0]                res_data_i,
  input  logic                             res_carry_i,
  output logic                             res_ready_o,
  output logic                             cin_o,
  output logic                             word_valid_o,
  output logic [MEM_WORD_SIZE-1:0]         word_data_o,
  input  logic                             word_ready_i,
  input  logic                             flush_i,
  input  logic                             ovf_clr_i,
  output logic                             ovf_o,
  output logic                             half_err_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  count_o
);
  import calculator_pkg::*;

  pack_state_t       state_q, state_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              cin_q, cin_d;
  logic              ovf_q, ovf_d;
  logic              herr_q, herr_d;
  logic              full, pop, accept, push;

  assign pop         = word_valid_o & word_ready_i;
  assign res_ready_o = ~rst_i & ((state_q == P_LOW) | ~full | pop);
  assign accept      = res_valid_i & res_ready_o & ~flush_i;
  assign cin_o       = cin_q;
  assign ovf_o       = ovf_q;
  assign half_err_o  = herr_q;

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    cin_d   = cin_q;
    push    = 1'b0;
    ovf_d   = ovf_clr_i ? 1'b0 : ovf_q;
    herr_d  = ovf_clr_i ? 1'b0 : herr_q;
    if (flush_i) begin
      state_d = P_LOW;
      cin_d   = 1'b0;
    end else if (accept) begin
      case (state_q)
        P_LOW: begin
          if (!res_half_i) begin
            lo_d    = res_data_i;
            cin_d   = res_carry_i;
            state_d = P_HIGH;
          end else begin
            herr_d = 1'b1;
          end
        end
        default: begin
          if (res_half_i) begin
            push    = 1'b1;
            ovf_d   = ovf_d | res_carry_i;
            cin_d   = 1'b0;
            state_d = P_LOW;
          end else begin
            // A second lower replaces the held one; the earlier pair is abandoned.
            lo_d   = res_data_i;
            cin_d  = res_carry_i;
            herr_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= P_LOW;
      lo_q    <= '0;
      cin_q   <= 1'b0;
      ovf_q   <= 1'b0;
      herr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      cin_q   <= cin_d;
      ovf_q   <= ovf_d;
      herr_q  <= herr_d;
    end
  end

  word_fifo #(
    .WIDTH (MEM_WORD_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  ({res_data_i, lo_q}),
    .pop_i   (pop),
    .flush_i (flush_i),
    .valid_o (word_valid_o),
    .data_o  (word_data_o),
    .full_o  (full),
    .count_o (count_o)
  );
endmodule

// File: tb/tb_result_packer.sv
// Random and directed stimulus for result_packer against a queue-based pairing model.
module tb_result_packer;
  localparam int D = 4;

  logic        clk = 1'b0, rst = 1'b1;
  logic        res_valid = 0, res_half = 0, res_carry = 0;
  logic [31:0] res_data = '0;
  logic        res_ready, cin, word_valid, word_ready = 0, flush = 0, ovf_clr = 0;
  logic        ovf, half_err;
  logic [63:0] word_data;
  logic [2:0]  count;

  int nchk = 0, nerr = 0;

  // Reference: a held lower half plus a queue of completed words.
  logic [63:0] mq[$];
  bit          m_have;
  logic [31:0] m_lo;
  bit          m_cin, m_ovf, m_herr;

  always #5 clk = ~clk;

  result_packer #(.DATA_W(32), .MEM_WORD_SIZE(64), .FIFO_DEPTH(D)) dut (
    .clk_i(clk), .rst_i(rst), .res_valid_i(res_valid), .res_half_i(res_half),
    .res_data_i(res_data), .res_carry_i(res_carry), .res_ready_o(res_ready),
    .cin_o(cin), .word_valid_o(word_valid), .word_data_o(word_data),
    .word_ready_i(word_ready), .flush_i(flush), .ovf_clr_i(ovf_clr),
    .ovf_o(ovf), .half_err_o(half_err), .count_o(count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_have = 0; m_lo = '0; m_cin = 0; m_ovf = 0; m_herr = 0;
  endtask

  task automatic idle();
    res_valid = 0; res_half = 0; res_data = '0; res_carry = 0;
    word_ready = 0; flush = 0; ovf_clr = 0;
  endtask

  // One clock: drive, compare every output with the model, advance the model.
  task automatic step(input bit v, input bit h, input logic [31:0] d, input bit c,
                      input bit wr, input bit fl, input bit clr);
    bit rdy, acc, pop, hset, oset;
    @(negedge clk);
    res_valid = v; res_half = h; res_data = d; res_carry = c;
    word_ready = wr; flush = fl; ovf_clr = clr;
    #1;
    rdy = !m_have || (mq.size() < D) || (mq.size() > 0 && wr);
    chk("ready", res_ready, rdy);
    chk("cin", cin, m_cin);
    chk("wvalid", word_valid, mq.size() != 0);
    chk("wdata", word_data, (mq.size() != 0) ? mq[0] : 64'h0);
    chk("count", count, mq.size());
    chk("ovf", ovf, m_ovf);
    chk("herr", half_err, m_herr);
    hset = 0; oset = 0;
    if (fl) begin
      mq.delete(); m_have = 0; m_cin = 0;
    end else begin
      acc = v && rdy;
      pop = wr && mq.size() != 0;
      if (pop) void'(mq.pop_front());
      if (acc) begin
        if (!m_have && !h) begin m_have = 1; m_lo = d; m_cin = c; end
        else if (!m_have && h) hset = 1;
        else if (m_have && !h) begin m_lo = d; m_cin = c; hset = 1; end
        else begin mq.push_back({d, m_lo}); m_have = 0; m_cin = 0; oset = c; end
      end
    end
    if (clr) begin m_ovf = 0; m_herr = 0; end
    m_ovf  = m_ovf | oset;
    m_herr = m_herr | hset;
    @(posedge clk); #1;
    idle();
  endtask

  initial begin
    model_clear();
    #1;
    chk("rst_ready", res_ready, 1'b0);
    chk("rst_count", count, 3'd0);
    chk("rst_wvalid", word_valid, 1'b0);
    chk("rst_wdata", word_data, 64'h0);
    @(negedge clk); @(negedge clk);
    rst = 0;

    // 1: basic pair with upper carry
    step(1, 0, 32'h0000_0001, 0, 0, 0, 0);
    step(1, 1, 32'hFFFF_FFFF, 1, 0, 0, 0);
    chk("s1_word", word_data, 64'hFFFFFFFF_00000001);
    chk("s1_valid", word_valid, 1'b1);
    chk("s1_ovf", ovf, 1'b1);
    chk("s1_count", count, 3'd1);

    // 2: lower carry held for the adder until the upper lands
    step(0, 0, 0, 0, 1, 0, 1);
    step(1, 0, 32'h8000_0000, 1, 0, 0, 0);
    chk("s2_cin_set", cin, 1'b1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("s2_cin_hold", cin, 1'b1);
    step(1, 1, 32'h1234_5678, 0, 0, 0, 0);
    chk("s2_cin_clr", cin, 1'b0);

    // 3: fill to depth, then push+pop on a full FIFO
    step(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 32'(i), 0, 0, 0, 0);
      step(1, 1, 32'hA000_0000 + 32'(i), 0, 0, 0, 0);
    end
    chk("s3_full", count, 3'd4);
    step(1, 0, 32'd4, 0, 0, 0, 0);
    chk("s3_stall", res_ready, 1'b0);
    step(1, 1, 32'hA000_0004, 0, 1, 0, 0);
    chk("s3_count", count, 3'd4);
    for (int i = 1; i <= 4; i++) begin
      chk("s3_order", word_data, {32'hA000_0000 + 32'(i), 32'(i)});
      step(0, 0, 0, 0, 1, 0, 0);
    end

    // 4: ordering errors and sticky clear
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 1, 32'hDEAD_BEEF, 0, 0, 0, 0);
    chk("s4_herr", half_err, 1'b1);
    chk("s4_drop", count, 3'd0);
    step(1, 0, 32'h1111_1111, 0, 0, 0, 0);
    step(1, 0, 32'h2222_2222, 0, 0, 0, 0);
    step(1, 1, 32'h3333_3333, 0, 0, 0, 0);
    chk("s4_second", word_data, 64'h33333333_22222222);
    step(0, 0, 0, 0, 1, 0, 1);
    chk("s4_clr_herr", half_err, 1'b0);
    chk("s4_clr_ovf", ovf, 1'b0);

    // 5: flush while holding a lower with two queued
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 32'h5000 + 32'(i), 0, 0, 0, 0);
      step(1, 1, 32'h6000 + 32'(i), 0, 0, 0, 0);
    end
    step(1, 0, 32'h7777, 1, 0, 0, 0);
    step(1, 1, 32'h8888, 0, 1, 1, 0);
    chk("s5_count", count, 3'd0);
    chk("s5_valid", word_valid, 1'b0);
    chk("s5_cin", cin, 1'b0);
    step(1, 1, 32'h9999, 0, 0, 0, 0);
    chk("s5_plow", half_err, 1'b1);

    // 6: asynchronous reset with three queued and a lower held
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 32'(i), 0, 0, 0, 0);
      step(1, 1, 32'(i) + 32'h40, 1, 0, 0, 0);
    end
    step(1, 0, 32'hABCD, 1, 0, 0, 0);
    #3 rst = 1;
    #1;
    chk("s6_count", count, 3'd0);
    chk("s6_valid", word_valid, 1'b0);
    chk("s6_data", word_data, 64'h0);
    chk("s6_ready", res_ready, 1'b0);
    chk("s6_cin", cin, 1'b0);
    chk("s6_ovf", ovf, 1'b0);
    chk("s6_herr", half_err, 1'b0);
    model_clear();
    @(negedge clk); @(negedge clk);
    rst = 0;

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, $urandom,
           $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 49) == 0, $urandom_range(0, 39) == 0);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
